// File: rtl/ram_sync_be_clr_pkg.sv
// ============================================================================
// Module : ram_sync_be_clr_pkg
// Brief  : Shared defaults, read-during-write modes and clear FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_sync_be_clr_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_BYTE_W = 8;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
// ============================================================================
// Module : ram_clear_ctrl
// Brief  : Clear FSM and sweep counter that zeroes the array after reset/request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_clear_ctrl
  import ram_sync_be_clr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_last;

  // Terminal-count compare: the counter wraps to 0 on the last write,
  // leaving it ready for the next sweep.
  assign w_last   = (r_cnt == {ADDR_W{1'b1}});
  assign clr_addr = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_we    = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ram_sync_be_clr.sv
// ============================================================================
// Module : ram_sync_be_clr
// Brief  : Single-port sync RAM with byte enables, registered read, HW clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_sync_be_clr
  import ram_sync_be_clr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYTE_W   = DEF_BYTE_W,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     we,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        din,
  input  logic                     re,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     err
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if ((DATA_W % BYTE_W) != 0) begin : g_cfg_err
    $fatal(1, "ram_sync_be_clr: DATA_W must be a multiple of BYTE_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_err;
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_we;
  logic              w_user_re;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_user_we = we & ~w_busy;
  assign w_user_re = re & ~w_busy;

  // Word as it will look after this cycle's write; used for RDW_NEW reads.
  always_comb begin
    w_merged = r_mem[addr];
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) w_merged[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  if (RDW_MODE == RDW_NEW) begin : g_rdw_new
    assign w_rd_word = w_merged;
  end else begin : g_rdw_old
    assign w_rd_word = r_mem[addr];
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) r_mem[addr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout_valid <= w_user_re;
      r_err        <= (we | re) & w_busy;
      if (w_user_re) r_dout <= w_rd_word;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = w_busy;
  assign err        = r_err;

endmodule

`default_nettype wire
